// File: rtl/out_drive_bank.sv
// Bank of output channels with a shadow/commit scheme.
// Writes stage a value into a per-channel shadow register; a commit
// publishes every pending channel to the registered ro output in one cycle.
module out_drive_bank #(
    parameter int WIDTH    = 2,
    parameter int CHANNELS = 4,
    parameter int CW       = 2
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      wr_valid,
    output logic                      wr_ready,
    input  logic [CW-1:0]             wr_chan,
    input  logic [WIDTH-1:0]          wr_data,
    input  logic                      commit,
    output logic [CHANNELS*WIDTH-1:0] ro,
    output logic [CHANNELS*WIDTH-1:0] wo,
    output logic [CHANNELS-1:0]       pending,
    output logic [7:0]                commit_count,
    output logic                      err
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        STAGED = 2'd1,
        COMMIT = 2'd2
    } state_t;

    state_t                      state;
    state_t                      state_next;
    logic [CHANNELS*WIDTH-1:0]   shadow;
    logic [CHANNELS-1:0]         chan_sel;
    logic                        in_range;
    logic                        accept;
    logic                        wr_en;

    // The net output is simply the staged contents.
    assign wo = shadow;

    // Decode the target channel; an index with no matching channel is out of range.
    always_comb begin
        // NOTE: every always_comb output gets a default first so no latch is inferred.
        chan_sel = '0;
        for (int k = 0; k < CHANNELS; k++) begin
            if (wr_chan == CW'(k)) begin
                chan_sel[k] = 1'b1;
            end
        end
    end

    assign in_range = |chan_sel;
    assign accept   = wr_valid && wr_ready;
    assign wr_en    = accept && in_range;

    // Next-state and ready logic: COMMIT lasts exactly one cycle and blocks writes.
    always_comb begin
        state_next = state;
        wr_ready   = 1'b1;
        case (state)
            IDLE: begin
                if (wr_en) begin
                    state_next = STAGED;
                end
            end
            STAGED: begin
                if (commit) begin
                    state_next = COMMIT;
                end
            end
            COMMIT: begin
                wr_ready   = 1'b0;
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // State register.
    always_ff @(posedge clk) begin
        // NOTE: sequential state is updated with non-blocking assignments only.
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Shadow and pending flags: stage accepted writes, clear pending on commit.
    always_ff @(posedge clk) begin
        // NOTE: the shadow storage is cleared by reset because wo is observable.
        if (rst) begin
            shadow  <= '0;
            pending <= '0;
        end else if (state == COMMIT) begin
            pending <= '0;
        end else if (wr_en) begin
            for (int k = 0; k < CHANNELS; k++) begin
                if (chan_sel[k]) begin
                    shadow[k*WIDTH +: WIDTH] <= wr_data;
                    pending[k]               <= 1'b1;
                end
            end
        end
    end

    // Published outputs and commit counter: copy only pending channels.
    always_ff @(posedge clk) begin
        if (rst) begin
            ro           <= '0;
            commit_count <= '0;
        end else if (state == COMMIT) begin
            for (int k = 0; k < CHANNELS; k++) begin
                if (pending[k]) begin
                    ro[k*WIDTH +: WIDTH] <= shadow[k*WIDTH +: WIDTH];
                end
            end
            commit_count <= commit_count + 8'd1;
        end
    end

    // Sticky error for accepted writes that address a nonexistent channel.
    always_ff @(posedge clk) begin
        if (rst) begin
            err <= 1'b0;
        end else if (accept && !in_range) begin
            err <= 1'b1;
        end
    end

endmodule

// File: doc/out_drive_bank.md
OUT_DRIVE_BANK -- requirements
Module: out_drive_bank

Interface
REQ-001 SHALL have parameter WIDTH, default 2, meaning bits per channel (legal range 1..32).
REQ-002 SHALL have parameter CHANNELS, default 4, meaning number of output channels (legal range 1..16).
REQ-003 SHALL have parameter CW, default 2, meaning channel-select width, ceil(log2(CHANNELS)) with a minimum of 1.
REQ-004 SHALL have port clk, input, 1 bit: the single clock; all state changes on rising edge.
REQ-005 SHALL have port rst, input, 1 bit: reset, synchronous and active-high.
REQ-006 SHALL have port wr_valid, input, 1 bit: write request.
REQ-007 SHALL have port wr_ready, output, 1 bit: write can be accepted this cycle.
REQ-008 SHALL have port wr_chan, input, CW bits: target channel index.
REQ-009 SHALL have port wr_data, input, WIDTH bits: value to stage.
REQ-010 SHALL have port commit, input, 1 bit: request to publish staged values.
REQ-011 SHALL have port ro, output, CHANNELS*WIDTH bits: committed values, procedurally driven output register; channel k at bits [k*WIDTH +: WIDTH].
REQ-012 SHALL have port wo, output, CHANNELS*WIDTH bits: net output, continuously assigned from the shadow register, same packing as ro.
REQ-013 SHALL have port pending, output, CHANNELS bits: channel has a staged value not yet committed.
REQ-014 SHALL have port commit_count, output, 8 bits: number of completed commits.
REQ-015 SHALL have port err, output, 1 bit: sticky flag, set by an out-of-range write.

Function
REQ-016 SHALL implement FSM states IDLE, STAGED and COMMIT.
REQ-017 SHALL drive wr_ready=1 in IDLE and STAGED, and wr_ready=0 in COMMIT.
REQ-018 SHALL accept a write when wr_valid && wr_ready: shadow[wr_chan] <= wr_data and pending[wr_chan] <= 1 on the same edge.
REQ-019 SHALL, on an accepted write with wr_chan >= CHANNELS, drop the write (shadow and pending unchanged) and set err=1 until rst.
REQ-020 SHALL drive wo continuously from the shadow register, so wo reflects an accepted write one cycle after acceptance.
REQ-021 SHALL transition IDLE->STAGED on any accepted in-range write, when commit is low or high.
REQ-022 SHALL ignore commit in IDLE; no state change and no count increment.
REQ-023 SHALL transition STAGED->COMMIT when commit=1; a write accepted in the same cycle updates shadow first and is included in the commit.
REQ-024 SHALL, in COMMIT (exactly one cycle), copy every channel with pending=1 from shadow to ro, clear all pending, increment commit_count modulo 256 (255->0), then go to IDLE.
REQ-025 SHALL keep ro channels with pending=0 unchanged during COMMIT.
REQ-026 SHALL ignore wr_valid during COMMIT (no write accepted); the requester holds wr_valid.
REQ-027 SHALL ignore commit asserted during COMMIT; no second commit occurs.
REQ-028 SHALL make latency from commit sampled high in STAGED to new ro visible equal to 2 edges.
REQ-029 SHALL let a later write to the same channel before commit overwrite the earlier staged value (last write wins).

Reset
REQ-030 SHALL, with rst=1 at an edge, set state=IDLE, ro=0, shadow=0 (wo=0), pending=0, commit_count=0 and err=0.
REQ-031 SHALL let rst override all other inputs, including a cycle in COMMIT; the interrupted commit does not update ro.
REQ-032 SHALL drive wr_ready=1 in the cycle after reset deasserts.

Verification
REQ-033 SHALL cover: reset, write ch1=2'b10 -> wo[3:2]=2'b10 next cycle, ro=0, pending=4'b0010.
REQ-034 SHALL cover: then commit=1 -> after 2 edges ro[3:2]=2'b10, pending=0, commit_count=1, other ro channels still 0.
REQ-035 SHALL cover: commit in IDLE -> commit_count unchanged, state IDLE.
REQ-036 SHALL cover: write ch0=2'b11 with commit high in STAGED in the same cycle -> ro[1:0]=2'b11 after 2 edges.
REQ-037 SHALL cover: CHANNELS=3, write wr_chan=3 -> err=1, wo and pending unchanged; err stays 1 across commits until rst.
REQ-038 SHALL cover: 256 commits -> commit_count wraps to 0; rst asserted in COMMIT -> ro=0, pending=0, commit_count=0.
